// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment pattern constants, event kinds and the pattern decoder.
package seg7_pkg;
    typedef enum logic [1:0] {DIGIT = 2'd0, BLANK = 2'd1, ILLEGAL = 2'd2} seg_kind_t;
    typedef struct packed {
        seg_kind_t  kind;
        logic [3:0] digit;
    } seg_dec_t;
    // Active-low patterns, bit 0 = segment a, bit 6 = segment g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    function automatic seg_dec_t seg7_decode(input logic [6:0] p);
        seg_dec_t d;
        d.kind  = DIGIT;
        d.digit = 4'd0;
        case (p)
            SEG_0:     d.digit = 4'd0;
            SEG_1:     d.digit = 4'd1;
            SEG_2:     d.digit = 4'd2;
            SEG_3:     d.digit = 4'd3;
            SEG_4:     d.digit = 4'd4;
            SEG_5:     d.digit = 4'd5;
            SEG_6:     d.digit = 4'd6;
            SEG_7:     d.digit = 4'd7;
            SEG_8:     d.digit = 4'd8;
            SEG_9:     d.digit = 4'd9;
            SEG_BLANK: d.kind  = BLANK;
            default:   d.kind  = ILLEGAL;
        endcase
        return d;
    endfunction
endpackage

// File: rtl/seg7_stabilizer.sv
// seg7_stabilizer: registers the segment lines and pulses o_commit once a pattern
// has matched for STABLE_CYCLES consecutive samples followed by one more matching sample.
module seg7_stabilizer
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] i_seg,
    output logic       o_commit,
    output logic [6:0] o_pattern
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    typedef enum logic {TRACK, STABLE} state_t;
    state_t        r_state;
    logic [6:0]    r_seg_q;
    logic [6:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic          r_commit;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= TRACK;
            r_seg_q  <= SEG_BLANK;
            r_cand   <= SEG_BLANK;
            r_cnt    <= '0;
            r_commit <= 1'b0;
        end else begin
            r_seg_q  <= i_seg;
            r_commit <= 1'b0;
            if (r_seg_q != r_cand) begin
                r_state <= TRACK;
                r_cand  <= r_seg_q;
                r_cnt   <= CW'(1);
            end else if (r_state == TRACK) begin
                // Saturated count plus a matching sample commits; the pulse marks STABLE entry
                if (r_cnt == CNT_MAX) begin
                    r_state  <= STABLE;
                    r_commit <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end
    assign o_commit  = r_commit;
    assign o_pattern = r_cand;
endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: loopback monitor turning stable seven-segment patterns into decoded
// events on a single-entry valid/ready holding register with a sticky overflow flag.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    input  logic       clr_ovf,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic [1:0] out_kind,
    output logic [6:0] out_raw,
    output logic       ovf
);
    logic       w_commit;
    logic [6:0] w_pattern;
    logic       w_event;
    logic       w_load;
    seg_dec_t   w_dec;
    logic [6:0] r_last;
    seg7_stabilizer #(.STABLE_CYCLES(STABLE_CYCLES)) u_stab (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_seg     (seg_in),
        .o_commit  (w_commit),
        .o_pattern (w_pattern)
    );
    assign w_event = w_commit && (w_pattern != r_last);
    assign w_load  = w_event && (!out_valid || out_ready);
    assign w_dec   = seg7_decode(w_pattern);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last    <= SEG_BLANK;
            out_valid <= 1'b0;
            out_digit <= 4'd0;
            out_kind  <= DIGIT;
            out_raw   <= SEG_BLANK;
            ovf       <= 1'b0;
        end else begin
            // last tracks every committed change, including dropped events
            if (w_event)
                r_last <= w_pattern;
            if (w_load) begin
                out_valid <= 1'b1;
                out_digit <= w_dec.digit;
                out_kind  <= w_dec.kind;
                out_raw   <= w_pattern;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            ovf <= (w_event && !w_load) ? 1'b1 : clr_ovf ? 1'b0 : ovf;
        end
    end
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed stimulus with a scoreboard queue of expected events,
// drained by an independent monitor on every accepted output handshake.
module tb_seg7_capture;
    import seg7_pkg::*;
    typedef struct packed {
        logic [3:0] digit;
        logic [1:0] kind;
        logic [6:0] raw;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h7F;
    logic       out_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       out_valid;
    logic [3:0] out_digit;
    logic [1:0] out_kind;
    logic [6:0] out_raw;
    logic       ovf;
    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [6:0] pats [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    seg7_capture #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_digit (out_digit),
        .out_kind  (out_kind),
        .out_raw   (out_raw),
        .ovf       (ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        cyc(n);
    endtask

    task automatic expect_ev(input logic [3:0] d, input logic [1:0] k, input logic [6:0] r);
        sb.push_back({d, k, r});
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid && out_ready) begin
            chk("event_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ev_digit", out_digit, e.digit);
                chk("ev_kind", out_kind, e.kind);
                chk("ev_raw", out_raw, e.raw);
            end
        end
    end

    initial begin
        cyc(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_digit", out_digit, 0);
        chk("rst_kind", out_kind, 0);
        chk("rst_raw", out_raw, 7'h7F);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc(10);
        chk("blank_after_reset", out_valid, 0);
        // Basic decode: valid exactly one cycle, after edge k+6
        expect_ev(4'd2, DIGIT, 7'h24);
        seg_in = 7'h24;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("basic_valid_timing", out_valid, int'(j == 7));
        end
        cyc(1);
        // Glitch rejection; the following blank differs from last committed digit 2
        hold(7'h30, 3);
        expect_ev(4'd0, BLANK, 7'h7F);
        hold(7'h7F, 8);
        expect_ev(4'd3, DIGIT, 7'h30);
        hold(7'h30, 5);
        // Full sweep
        for (int i = 0; i < 10; i++) begin
            expect_ev(4'(i), DIGIT, pats[i]);
            hold(pats[i], 8);
        end
        expect_ev(4'd0, BLANK, 7'h7F);
        hold(7'h7F, 8);
        expect_ev(4'd0, ILLEGAL, 7'h55);
        hold(7'h55, 8);
        cyc(4);
        chk("sweep_drained", out_valid, 0);
        // Backpressure
        out_ready = 1'b0;
        expect_ev(4'd1, DIGIT, 7'h79);
        hold(7'h79, 8);
        hold(7'h12, 8);
        chk("bp_ovf_set", ovf, 1);
        chk("bp_valid_held", out_valid, 1);
        chk("bp_digit_held", out_digit, 1);
        out_ready = 1'b1;
        cyc(4);
        chk("bp_popped", out_valid, 0);
        chk("bp_ovf_sticky", ovf, 1);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        chk("bp_ovf_cleared", ovf, 0);
        // Repeat suppression
        expect_ev(4'd6, DIGIT, 7'h02);
        hold(7'h02, 8);
        hold(7'h00, 2);
        hold(7'h02, 8);
        chk("repeat_silent", out_valid, 0);
        // Reset mid-operation: pending digit 4 and dropped digit 9 are discarded
        out_ready = 1'b0;
        hold(7'h19, 8);
        hold(7'h10, 8);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_ovf", ovf, 1);
        rst_n = 1'b0;
        seg_in = 7'h7F;
        cyc(1);
        rst_n = 1'b1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ovf", ovf, 0);
        out_ready = 1'b1;
        cyc(12);
        chk("post_rst_no_event", out_valid, 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seg7_capture.md
# seg7_capture

Seven-segment capture and decode monitor: watches the active-low segment lines driven by the display encoder, waits until a pattern has been stable for a programmable number of cycles, then decodes it back to a BCD digit and presents it on a valid/ready output. It sits beside the display path as a loopback checker, letting the processor self-test, or a bench, read back what is being displayed.

## Interface

Parameters:
- `STABLE_CYCLES`, default 4. Consecutive identical samples required before a pattern is committed. Legal range 1..255.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, synchronous and active-low.
- `seg_in`  in  7  Observed segments, active-low. Bit 0 = a, bit 6 = g.
- `out_ready`  in  1  Consumer accepts the current event.
- `clr_ovf`  in  1  Clears the sticky `ovf` flag.
- `out_valid`  out  1  Event pending.
- `out_digit`  out  4  Decoded digit, 0..9. Value is 0 for non-digit kinds.
- `out_kind`  out  2  Event kind: 0 = DIGIT, 1 = BLANK, 2 = ILLEGAL.
- `out_raw`  out  7  Committed raw pattern.
- `ovf`  out  1  Sticky flag: an event was dropped because the holding register was full.

## Operation

- **Decode table** (`seg_in` hex → digit):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - 7F → BLANK.
  - Any other pattern → ILLEGAL.
- **Input register:** `seg_in` is registered into `seg_q` every cycle with no qualification.
- **FSM states:**
  - TRACK: compares `seg_q` against candidate `cand`.
    - On mismatch: `cand` ← `seg_q`, `cnt` ← 1.
    - On match: `cnt` increments, saturating at `STABLE_CYCLES`.
    - When `cnt` reaches `STABLE_CYCLES`, go to STABLE.
  - STABLE: `cand` is committed.
    - On entry, if `cand` ≠ `last`, raise an event and set `last` ← `cand`.
    - If `cand` = `last`, no event is raised (a re-stabilised identical pattern is silent).
    - Any mismatch returns to TRACK with `cand` ← `seg_q`, `cnt` ← 1.
- **Holding register** (single entry: `out_valid`, `out_digit`, `out_kind`, `out_raw`):
  - An event loads it when it is empty, or when it is being popped in the same cycle (`out_valid && out_ready`).
  - Otherwise the new event is dropped, `ovf` ← 1, and the held event is unchanged.
  - `out_valid` stays high and the payload stays stable until `out_ready` is sampled high.
- **`ovf` flag:** cleared by `clr_ovf`. If set and clear happen in the same cycle, set wins.
- **`cnt` width:** $clog2(STABLE_CYCLES+1). `cnt` never wraps.
- **Reset state:**
  - State TRACK.
  - `seg_q`, `cand` and `last` = 7'h7F, `cnt` = 0.
  - `out_valid` = 0, `out_digit` = 0, `out_kind` = 0, `out_raw` = 7'h7F, `ovf` = 0.
  - A blank display after reset therefore produces no event.
- **Reset mid-operation:** a pending event is discarded and no event is produced during reset.

## Timing

- **Latency:** `seg_in` constant across edges k..k+STABLE_CYCLES, with a different prior committed pattern → `out_valid` high after edge k+STABLE_CYCLES+2 (input register, counting, output register).
- **Glitches:** a pattern shorter than `STABLE_CYCLES` samples never produces an event and does not change `last`.
- **Throughput:** at most one event per `STABLE_CYCLES`+1 cycles. Back-to-back events are sustained when `out_ready` is held high.
- **Handshake:** `out_ready` while `out_valid` = 0 has no effect.
- **Combinational paths:** none from inputs to outputs.

## Structure

- **Shared package `seg7_pkg`:**
  - `seg_kind_t` enum (DIGIT, BLANK, ILLEGAL).
  - Pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - Pure function `seg7_decode(pattern) → {kind, digit}`.
  - The display encoder should share these constants.
- **Sub-module:** one, `seg7_stabilizer` (input register, `cand`/`cnt` FSM, commit pulse plus committed pattern).
- **Top level:** the holding register, `last` comparison and `ovf` logic.

## Test plan

- **Basic decode:** reset, then `seg_in`=7'h24 for 10 cycles with `out_ready`=1, `STABLE_CYCLES`=4 → exactly one event, `out_digit`=2, `out_kind`=DIGIT, `out_valid` high after edge k+6, for one cycle.
- **Glitch rejection:** `seg_in`=7'h30 for 3 cycles, then 7'h7F → no event. Then 7'h30 for 5 cycles → one event, digit 3.
- **Full sweep:** all ten digit patterns, each held 8 cycles → digits 0..9 in order. 7'h7F → BLANK. 7'h55 → ILLEGAL with `out_raw`=7'h55.
- **Backpressure:** `out_ready`=0, apply 7'h79 then 7'h12 (8 cycles each) → digit 1 held, `ovf`=1. Raise `out_ready` → digit 1 popped, no digit 5 event. Pulse `clr_ovf` → `ovf`=0.
- **Repeat suppression:** 7'h02 stable, 2-cycle glitch to 7'h00, back to 7'h02 → only one event (digit 6).
- **Reset mid-operation:** event pending with `out_ready`=0, assert `rst_n`=0 for 1 cycle → `out_valid`=0, `ovf`=0. 7'h7F afterwards → no event.
